// File: rtl/axi_rd_burst_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant, one INCR burst
// in flight, R beats steered to the owning requester's stream.
module axi_rd_burst_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [7:0]            req0_len,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [7:0]            req1_len,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [1:0]            s_axi_arburst,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  done0_q;
    logic                  done1_q;

    logic grant1;
    logic accept;
    logic own_ready;
    logic beat;
    logic last_beat;

    // Requester 1 wins when alone, or on a tie when 0 went last.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant1;
        req1_ready = !rst && (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        own_ready    = owner ? out1_ready : out0_ready;
        s_axi_rready = (state == DATA) && own_ready;
        out0_valid   = (state == DATA) && !owner && s_axi_rvalid;
        out1_valid   = (state == DATA) && owner && s_axi_rvalid;
        beat         = s_axi_rvalid && s_axi_rready;
        last_beat    = beat && (beat_cnt == len_q);
    end

    assign out0_data     = s_axi_rdata;
    assign out1_data     = s_axi_rdata;
    assign s_axi_araddr  = addr_q;
    assign s_axi_arlen   = len_q;
    assign s_axi_arburst = 2'd1;
    assign s_axi_arsize  = 3'd2;
    assign s_axi_arvalid = (state == ADDR);
    assign busy          = (state != IDLE);
    assign done0         = done0_q;
    assign done1         = done1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= grant1;
                        addr_q   <= grant1 ? req1_addr : req0_addr;
                        len_q    <= grant1 ? req1_len : req0_len;
                        beat_cnt <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    // Compare before increment so len 255 never wraps.
                    if (last_beat) begin
                        last_grant <= owner;
                        done0_q    <= !owner;
                        done1_q    <= owner;
                        state      <= IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Bench for axi_rd_burst_arbiter: directed steps plus a random phase,
// checked against a transaction-level model of grants, beats and dones.
module tb_axi_rd_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv;
    logic [15:0] ra [2];
    logic [7:0]  rl [2];
    logic [1:0]  ordy;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rvalid;

    logic        req0_ready, req1_ready;
    logic [15:0] s_axi_araddr;
    logic [1:0]  s_axi_arburst;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic        s_axi_arvalid, s_axi_rready;
    logic [31:0] out0_data, out1_data;
    logic        out0_valid, out1_valid;
    logic        done0, done1, busy;

    always #5 clk = ~clk;

    axi_rd_burst_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(req0_ready),
        .req0_addr(ra[0]), .req0_len(rl[0]),
        .req1_valid(rv[1]), .req1_ready(req1_ready),
        .req1_addr(ra[1]), .req1_len(rl[1]),
        .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(ordy[0]),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(ordy[1]),
        .done0(done0), .done1(done1), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // requester intent, applied at the next drive point
    bit [1:0]    q_v = 2'b00;
    logic [15:0] q_a [2];
    logic [7:0]  q_l [2];
    bit [1:0]    hold = 2'b00;
    bit          rand_mode = 1'b0;

    // sink modes: 0 always ready, 1 random, 2 pattern 1,0,0,1
    int rmode [2];
    int pcnt = 0;

    // slave model
    bit          s_busy = 1'b0;
    bit          s_rv = 1'b0;
    logic [15:0] s_addr;
    int          s_len, s_idx, s_stall = 0;
    bit          always_rv = 1'b1;

    // reference model
    bit          m_busy = 1'b0, m_ar_done = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    logic [15:0] m_addr;
    int          m_len = 0, m_beats = 0;
    bit [1:0]    m_done = 2'b00;
    int          got [2];
    int          dones [2];
    int          arcyc = 0;
    bit          grants [$];

    function automatic logic [31:0] pat(input logic [15:0] a, input int i);
        return {a, 16'(i) + 16'h00A0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        got[0] = 0; got[1] = 0; dones[0] = 0; dones[1] = 0;
        arcyc = 0; grants.delete();
    endtask

    task automatic drive(input bit r);
        rst = r;
        if (rand_mode) begin
            for (int n = 0; n < 2; n++) begin
                if (!q_v[n] && ($urandom % 4 == 0)) begin
                    q_v[n] = 1'b1;
                    q_a[n] = 16'($urandom);
                    q_l[n] = 8'($urandom % 8);
                end else if (q_v[n] && ($urandom % 32 == 0)) begin
                    q_v[n] = 1'b0;
                end
            end
        end
        rv = q_v; ra[0] = q_a[0]; ra[1] = q_a[1]; rl[0] = q_l[0]; rl[1] = q_l[1];
        for (int n = 0; n < 2; n++) begin
            case (rmode[n])
                1: ordy[n] = 1'($urandom_range(0, 1));
                2: ordy[n] = (pcnt % 4 == 0) || (pcnt % 4 == 3);
                default: ordy[n] = 1'b1;
            endcase
        end
        pcnt++;
        s_axi_arready = !s_busy && (s_stall == 0);
        if (s_busy && !s_rv) s_rv = always_rv ? 1'b1 : 1'($urandom_range(0, 1));
        s_axi_rvalid = s_busy && s_rv;
        s_axi_rdata = pat(s_addr, s_idx);
    endtask

    task automatic check_and_model();
        bit [1:0] rdy_e;
        bit w, acc, arhs, bt, sl_ar, sl_r;
        w = 1'b0;
        chk("busy", busy, m_busy);
        chk("done0", done0, m_done[0]);
        chk("done1", done1, m_done[1]);
        rdy_e = 2'b00;
        if (!m_busy && rv != 2'b00) begin
            if (rv == 2'b11) w = !m_last;
            else w = rv[1];
            rdy_e[w] = 1'b1;
        end
        chk("req0_ready", req0_ready, rdy_e[0]);
        chk("req1_ready", req1_ready, rdy_e[1]);
        chk("arvalid", s_axi_arvalid, m_busy && !m_ar_done);
        if (m_busy && !m_ar_done) begin
            chk("araddr", s_axi_araddr, m_addr);
            chk("arlen", s_axi_arlen, m_len);
            chk("arburst", s_axi_arburst, 1);
            chk("arsize", s_axi_arsize, 2);
        end
        if (m_busy && m_ar_done) begin
            chk("rready", s_axi_rready, ordy[m_owner]);
            chk("own_valid", m_owner ? out1_valid : out0_valid, s_axi_rvalid);
            chk("other_valid", m_owner ? out0_valid : out1_valid, 0);
            if (s_axi_rvalid)
                chk("beat_data", m_owner ? out1_data : out0_data,
                    pat(m_addr, m_beats));
        end else begin
            chk("rready_idle", s_axi_rready, 0);
            chk("out0_valid_idle", out0_valid, 0);
            chk("out1_valid_idle", out1_valid, 0);
        end

        acc   = (rdy_e != 2'b00);
        arhs  = m_busy && !m_ar_done && s_axi_arready;
        bt    = m_busy && m_ar_done && s_axi_rvalid && ordy[m_owner];
        sl_ar = s_axi_arvalid && s_axi_arready;
        sl_r  = s_axi_rvalid && s_axi_rready;

        if (m_busy && !m_ar_done) arcyc++;
        m_done = 2'b00;
        if (acc) begin
            m_busy = 1'b1; m_ar_done = 1'b0; m_owner = w;
            m_addr = ra[w]; m_len = int'(rl[w]); m_beats = 0;
            grants.push_back(w);
            if (!hold[w]) q_v[w] = 1'b0;
        end
        if (arhs) m_ar_done = 1'b1;
        if (bt) begin
            got[m_owner]++;
            if (m_beats == m_len) begin
                m_busy = 1'b0; m_last = m_owner;
                m_done[m_owner] = 1'b1; dones[m_owner]++;
            end else begin
                m_beats++;
            end
        end

        if (sl_ar) begin
            s_busy = 1'b1; s_addr = s_axi_araddr; s_len = int'(s_axi_arlen);
            s_idx = 0; s_rv = 1'b0;
            s_stall = rand_mode ? $urandom_range(0, 3) : 0;
        end else if (s_axi_arvalid && s_stall > 0) begin
            s_stall--;
        end
        if (sl_r) begin
            s_rv = 1'b0;
            if (s_idx == s_len) s_busy = 1'b0;
            else s_idx++;
        end
    endtask

    task automatic tick(input bit r);
        @(posedge clk);
        #1;
        drive(r);
        #1;
        if (r) begin
            m_busy = 1'b0; m_ar_done = 1'b0; m_last = 1'b1; m_done = 2'b00;
            s_busy = 1'b0; s_rv = 1'b0;
        end else begin
            check_and_model();
        end
    endtask

    task automatic run_until_done(input int bound, input string tag);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < bound) begin
            tick(1'b0);
            n++;
            if (m_done != 2'b00) seen = 1'b1;
        end
        chk(tag, seen, 1);
        tick(1'b0);
    endtask

    task automatic drain(input int bound, input string tag);
        int n;
        n = 0;
        while (m_busy && n < bound) begin
            tick(1'b0);
            n++;
        end
        chk(tag, m_busy, 0);
        tick(1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rv = 2'b00; ordy = 2'b11;
        s_axi_arready = 1'b0; s_axi_rvalid = 1'b0; s_axi_rdata = '0;
        q_a[0] = '0; q_a[1] = '0; q_l[0] = '0; q_l[1] = '0;
        rmode[0] = 0; rmode[1] = 0;
        s_addr = '0; s_len = 0; s_idx = 0; m_addr = '0;
        clear_counts();
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);

        // single request
        q_v[0] = 1'b1; q_a[0] = 16'h0100; q_l[0] = 8'd3;
        run_until_done(40, "single_timeout");
        repeat (3) tick(1'b0);
        chk("single_beats", got[0], 4);
        chk("single_arcyc", arcyc, 1);
        chk("single_done_count", dones[0], 1);
        chk("single_other_beats", got[1], 0);

        // tie and round robin from reset
        tick(1'b1);
        clear_counts();
        hold = 2'b11;
        q_v = 2'b11; q_a[0] = 16'h0200; q_a[1] = 16'h0300;
        q_l[0] = 8'd1; q_l[1] = 8'd1;
        n = 0;
        while (grants.size() < 4 && n < 100) begin
            tick(1'b0);
            n++;
        end
        q_v = 2'b00; hold = 2'b00;
        drain(50, "rr_drain");
        chk("rr_grant_count", grants.size(), 4);
        if (grants.size() >= 4) begin
            chk("rr_grant0", grants[0], 0);
            chk("rr_grant1", grants[1], 1);
            chk("rr_grant2", grants[2], 0);
            chk("rr_grant3", grants[3], 1);
        end

        // backpressure on requester 1
        clear_counts();
        rmode[1] = 2; pcnt = 0;
        q_v[1] = 1'b1; q_a[1] = 16'h0400; q_l[1] = 8'd7;
        run_until_done(100, "bp_timeout");
        chk("bp_beats", got[1], 8);
        chk("bp_done_count", dones[1], 1);
        rmode[1] = 0;

        // slow slave
        clear_counts();
        s_stall = 5;
        q_v[0] = 1'b1; q_a[0] = 16'h0500; q_l[0] = 8'd2;
        run_until_done(60, "slow_timeout");
        chk("slow_arcyc", arcyc, 6);
        chk("slow_beats", got[0], 3);

        // boundary lengths
        clear_counts();
        q_v[0] = 1'b1; q_a[0] = 16'h0600; q_l[0] = 8'd0;
        run_until_done(20, "len0_timeout");
        chk("len0_beats", got[0], 1);
        q_v[1] = 1'b1; q_a[1] = 16'h0680; q_l[1] = 8'd255;
        run_until_done(600, "len255_timeout");
        chk("len255_beats", got[1], 256);
        chk("len255_done_count", dones[1], 1);

        // reset in the middle of the data phase
        clear_counts();
        q_v[0] = 1'b1; q_a[0] = 16'h0700; q_l[0] = 8'd3;
        n = 0;
        while (got[0] < 2 && n < 30) begin
            tick(1'b0);
            n++;
        end
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        chk("midrst_no_done", dones[0], 0);
        got[0] = 0;
        q_v[0] = 1'b1; q_a[0] = 16'h0780; q_l[0] = 8'd1;
        run_until_done(30, "postrst_timeout");
        chk("postrst_beats", got[0], 2);
        chk("postrst_done_count", dones[0], 1);

        // randomized traffic
        clear_counts();
        rmode[0] = 1; rmode[1] = 1; always_rv = 1'b0; rand_mode = 1'b1;
        repeat (3000) tick(1'b0);
        rand_mode = 1'b0; q_v = 2'b00;
        tick(1'b0);
        drain(2000, "rand_drain");
        chk("rand_bursts_done", dones[0] + dones[1], grants.size());
        chk("rand_some_bursts", grants.size() > 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
